// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and sequencer state encoding shared by the accumulator CPU
package cpu_pkg;
  localparam logic [3:0] LDA = 4'd0;
  localparam logic [3:0] STA = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;
  localparam logic [3:0] JMP = 4'd4;
  localparam logic [3:0] JMI = 4'd5;
  localparam logic [3:0] JEQ = 4'd6;
  localparam logic [3:0] STP = 4'd7;
  localparam logic [3:0] LDI = 4'd8;
  localparam int OPC_MAX_LEGAL = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_EXEC1, ST_EXEC2, ST_HALT} seq_state_t;
endpackage

// File: rtl/cpu_sequencer_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] Q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = (INC && q_q != '1) ? q_q + 1'b1 : q_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) q_q <= '0;
    else q_q <= q_d;
  assign Q = q_q;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute phase sequencer with run, single-step and halt control
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     RUN,
  input  logic                     STEP,
  input  logic [INSTR_W-1:0]       INSTR,
  input  logic                     EXTRA,
  output logic                     FETCH,
  output logic                     EXEC1,
  output logic                     EXEC2,
  output logic [OPC_W-1:0]         IR,
  output logic [INSTR_W-OPC_W-1:0] OPERAND,
  output logic                     BUSY,
  output logic                     HALTED,
  output logic                     ILLEGAL,
  output logic                     INSTR_DONE,
  output logic [CNT_W-1:0]         CYCLE_CNT,
  output logic [CNT_W-1:0]         INSTR_CNT
);
  seq_state_t state_q, state_d;
  logic [OPC_W-1:0] ir_q, ir_d;
  logic [INSTR_W-OPC_W-1:0] operand_q, operand_d;
  logic illegal_q, illegal_d;
  logic fetch_q, exec1_q, exec2_q, busy_q, halted_q;
  logic stp, bad, done;
  assign stp = ir_q == OPC_W'(STP);
  assign bad = ir_q > OPC_W'(OPC_MAX_LEGAL);
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    done      = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = (RUN || STEP) ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        ir_d      = INSTR[INSTR_W-1 -: OPC_W];
        operand_d = INSTR[INSTR_W-OPC_W-1:0];
        state_d   = ST_EXEC1;
      end
      ST_EXEC1: begin
        done      = stp || bad || !EXTRA;
        illegal_d = bad;
        state_d   = (stp || bad) ? ST_HALT : EXTRA ? ST_EXEC2 : RUN ? ST_FETCH : ST_IDLE;
      end
      ST_EXEC2: begin
        done    = 1'b1;
        state_d = RUN ? ST_FETCH : ST_IDLE;
      end
      default: ;
    endcase
  end
  // strobes are decoded from the next state so they line up with the state register
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      operand_q <= '0;
      illegal_q <= 1'b0;
      fetch_q   <= 1'b0;
      exec1_q   <= 1'b0;
      exec2_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
      illegal_q <= illegal_d;
      fetch_q   <= state_d == ST_FETCH;
      exec1_q   <= state_d == ST_EXEC1;
      exec2_q   <= state_d == ST_EXEC2;
      busy_q    <= state_d inside {ST_FETCH, ST_EXEC1, ST_EXEC2};
      halted_q  <= state_d == ST_HALT;
    end
  assign FETCH      = fetch_q;
  assign EXEC1      = exec1_q;
  assign EXEC2      = exec2_q;
  assign IR         = ir_q;
  assign OPERAND    = operand_q;
  assign BUSY       = busy_q;
  assign HALTED     = halted_q;
  assign ILLEGAL    = illegal_q;
  assign INSTR_DONE = done;
  sat_counter #(.W(CNT_W)) u_cycle_cnt (.CLK(CLK), .RESET(RESET), .INC(busy_q), .Q(CYCLE_CNT));
  sat_counter #(.W(CNT_W)) u_instr_cnt (.CLK(CLK), .RESET(RESET), .INC(done), .Q(INSTR_CNT));
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized bench with an instruction-level reference model; a 4-bit-counter twin covers saturation
module tb_cpu_sequencer;
  logic CLK = 1'b0, RESET = 1'b0, RUN = 1'b0, STEP = 1'b0, EXTRA = 1'b0;
  logic [15:0] INSTR = '0;
  logic FETCH, EXEC1, EXEC2, BUSY, HALTED, ILLEGAL, INSTR_DONE;
  logic [3:0] IR;
  logic [11:0] OPERAND;
  logic [15:0] CYCLE_CNT, INSTR_CNT;
  logic s_fetch, s_exec1, s_exec2, s_busy, s_halted, s_illegal, s_done;
  logic [3:0] s_ir, s_cyc, s_ins;
  logic [11:0] s_op;
  cpu_sequencer dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .INSTR(INSTR), .EXTRA(EXTRA),
    .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .IR(IR), .OPERAND(OPERAND),
    .BUSY(BUSY), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .INSTR_DONE(INSTR_DONE),
    .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
  );
  cpu_sequencer #(.CNT_W(4)) dut_s (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .INSTR(INSTR), .EXTRA(EXTRA),
    .FETCH(s_fetch), .EXEC1(s_exec1), .EXEC2(s_exec2), .IR(s_ir), .OPERAND(s_op),
    .BUSY(s_busy), .HALTED(s_halted), .ILLEGAL(s_illegal), .INSTR_DONE(s_done),
    .CYCLE_CNT(s_cyc), .INSTR_CNT(s_ins)
  );
  always #5 CLK = ~CLK;
  int n_chk = 0, n_fail = 0;
  logic [15:0] prog [64];
  bit pext [64];
  int pc = 0;
  int ph_q[$];
  bit halted = 0, illegal = 0;
  int cyc = 0, ins = 0;
  logic [3:0] m_ir = '0;
  logic [11:0] m_op = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int sat4(input int v);
    return v > 15 ? 15 : v;
  endfunction
  // queue the phases an instruction will take: F, E1 and E2 only for a legal non-STP op with EXTRA
  function automatic void start();
    logic [3:0] opc;
    opc = prog[pc % 64][15:12];
    ph_q = '{1, 2};
    if (opc <= 4'd8 && opc != 4'd7 && pext[pc % 64]) ph_q.push_back(3);
  endfunction
  task automatic advance();
    if (ph_q.size() == 0) begin
      if (!halted && (RUN || STEP)) start();
    end else begin
      cyc++;
      if (ph_q[0] == 1) begin
        m_ir = prog[pc % 64][15:12];
        m_op = prog[pc % 64][11:0];
      end
      void'(ph_q.pop_front());
      if (ph_q.size() == 0) begin
        ins++;
        pc++;
        if (m_ir == 4'd7 || m_ir > 4'd8) begin
          halted  = 1;
          illegal = m_ir != 4'd7;
        end else if (RUN) start();
      end
    end
  endtask
  task automatic check_all();
    int ph;
    logic [6:0] e;
    ph = ph_q.size() != 0 ? ph_q[0] : 0;
    e = {ph == 1, ph == 2, ph == 3, ph != 0, halted, illegal, ph_q.size() == 1};
    chk("ctl", {FETCH, EXEC1, EXEC2, BUSY, HALTED, ILLEGAL, INSTR_DONE}, e);
    chk("s_ctl", {s_fetch, s_exec1, s_exec2, s_busy, s_halted, s_illegal, s_done}, e);
    chk("irop", {IR, OPERAND}, {m_ir, m_op});
    chk("s_irop", {s_ir, s_op}, {m_ir, m_op});
    chk("cyc", CYCLE_CNT, cyc);
    chk("ins", INSTR_CNT, ins);
    chk("s_cyc", s_cyc, sat4(cyc));
    chk("s_ins", s_ins, sat4(ins));
  endtask
  task automatic cycle(input bit run, input bit step);
    int ph;
    @(negedge CLK);
    ph = ph_q.size() != 0 ? ph_q[0] : 0;
    RUN = run;
    STEP = step;
    INSTR = ph == 1 ? prog[pc % 64] : 16'($urandom);
    EXTRA = ph == 2 ? pext[pc % 64] : 1'($urandom);
    #1 check_all();
    @(posedge CLK);
    advance();
  endtask
  task automatic do_reset();
    #2;
    RESET = 1;
    RUN = 0;
    STEP = 0;
    ph_q.delete();
    halted = 0; illegal = 0; cyc = 0; ins = 0; m_ir = '0; m_op = '0; pc = 0;
    #1 check_all();
    @(negedge CLK);
    RESET = 0;
  endtask
  initial begin
    bit run;
    int r;
    logic [3:0] opc;
    for (int i = 0; i < 64; i++) begin prog[i] = 16'h4000; pext[i] = 0; end
    do_reset();
    repeat (10) cycle(0, 0);
    // free run: LDA (extra), STA, STP
    prog[0] = 16'h0005; pext[0] = 1;
    prog[1] = 16'h1006; pext[1] = 0;
    prog[2] = 16'h7000; pext[2] = 1;
    for (int i = 0; i < 12 && !halted; i++) cycle(1, 0);
    repeat (6) cycle(1, 1'($urandom));
    #2;
    chk("fr_halted", HALTED, 1);
    chk("fr_illegal", ILLEGAL, 0);
    chk("fr_ins", INSTR_CNT, 3);
    chk("fr_cyc", CYCLE_CNT, 7);
    // reset in the middle of EXEC2
    do_reset();
    prog[0] = 16'h2010; pext[0] = 1;
    for (int i = 0; i < 8 && !(ph_q.size() != 0 && ph_q[0] == 3); i++) cycle(1, 0);
    #1 chk("e2_before_rst", EXEC2, 1);
    do_reset();
    // single step, with a second STEP during EXEC1
    cycle(0, 1); cycle(0, 0); cycle(0, 1); cycle(0, 0);
    repeat (4) cycle(0, 0);
    #2;
    chk("ss_ins", INSTR_CNT, 1);
    chk("ss_cyc", CYCLE_CNT, 3);
    chk("ss_ir", IR, 2);
    chk("ss_op", OPERAND, 12'h010);
    // drop RUN during EXEC1 of an EXTRA instruction
    do_reset();
    prog[0] = 16'h3055; pext[0] = 1;
    prog[1] = 16'h1000; pext[1] = 0;
    cycle(1, 0); cycle(1, 0); cycle(0, 0); cycle(0, 0);
    repeat (3) cycle(0, 0);
    #2;
    chk("rd_ins", INSTR_CNT, 1);
    chk("rd_busy", BUSY, 0);
    // illegal opcode halts and stays halted
    do_reset();
    prog[0] = 16'hA123; pext[0] = 0;
    cycle(0, 1); cycle(0, 0); cycle(0, 0);
    repeat (10) cycle(1'($urandom), 1'($urandom));
    #2;
    chk("il_halted", HALTED, 1);
    chk("il_illegal", ILLEGAL, 1);
    chk("il_ins", INSTR_CNT, 1);
    chk("il_cyc", CYCLE_CNT, 2);
    // randomized programs and controls
    repeat (6) begin
      do_reset();
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 99);
        opc = r < 3 ? 4'd7 : r < 6 ? 4'(9 + $urandom_range(0, 6)) : 4'($urandom_range(0, 8));
        prog[i] = {opc, 12'($urandom)};
        pext[i] = 1'($urandom);
      end
      run = 0;
      repeat (200) begin
        if ($urandom_range(0, 15) == 0) run = !run;
        cycle(run, $urandom_range(0, 3) == 0);
      end
    end
    // saturation of the 4-bit twin with a 2-cycle JMP stream
    do_reset();
    for (int i = 0; i < 64; i++) begin prog[i] = 16'h4000; pext[i] = 0; end
    repeat (40) cycle(1, 0);
    #2;
    chk("sat_s_cyc", s_cyc, 15);
    chk("sat_s_ins", s_ins, 15);
    chk("sat_cyc", CYCLE_CNT, 39);
    chk("sat_ins", INSTR_CNT, 19);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
